ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter_pkg.sv | 17 +
 rtl/ram_port_arbiter_if.sv | 32 +++
 rtl/arb_return_pipe.sv | 34 +++
 rtl/ram_port_arbiter.sv | 118 +++++++++++
 tb/tb_ram_port_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared widths, FSM encoding and read-return slot type for the RAM port arbiter.
package ram_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  // One slot of the read-return tracker: the read is live and which requester issued it.
  typedef struct packed {
    logic valid;
    logic tag;
  } ret_slot_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-port-B signal bundle; the arbiter uses the slave modport.
interface ram_port_arbiter_if import ram_port_arbiter_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req0, req1;
  logic              we0, we1;
  logic              lock0, lock1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] data_to_ram;
  logic              web;
  logic [DATA_W-1:0] data_from_ram;

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    output data_from_ram,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_address, data_to_ram, web
  );

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    input  data_from_ram,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_address, data_to_ram, web
  );

endinterface

// File: rtl/arb_return_pipe.sv
// Two-stage read-return tracker: a read issued at edge T is reported back to its
// requester during the cycle after edge T+1, when the RAM's registered data is out.
module arb_return_pipe import ram_port_arbiter_pkg::*; (
  input  logic clk,
  input  logic reset_n,
  input  logic issue_valid,
  input  logic issue_tag,
  output logic rvalid0,
  output logic rvalid1
);

  ret_slot_t s1_q, s1_d;
  ret_slot_t s2_q, s2_d;

  always_comb begin
    s1_d.valid = issue_valid;
    s1_d.tag   = issue_tag;
    s2_d       = s1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign rvalid0 = s2_q.valid & ~s2_q.tag;
  assign rvalid1 = s2_q.valid &  s2_q.tag;

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a single RAM port: round-robin grants with optional
// lock, registered command stage to the RAM and tagged read-data return.
module ram_port_arbiter import ram_port_arbiter_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  ram_port_arbiter_if.slave bus
);

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              gnt0, gnt1;
  logic              hs0, hs1;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] data_to_ram_q, data_to_ram_d;
  logic              web_q, web_d;
  logic              issue_valid, issue_tag;
  logic              ret_valid0, ret_valid1;

  // Grants are combinational so a lone requester completes in the same cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      case (state_q)
        ST_LOCK0: gnt0 = bus.req0;
        ST_LOCK1: gnt1 = bus.req1;
        default: begin
          if (bus.req0 && bus.req1) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
          end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
          end
        end
      endcase
    end
  end

  assign hs0 = bus.req0 & gnt0;
  assign hs1 = bus.req1 & gnt1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (hs0) last_d = 1'b0;
    if (hs1) last_d = 1'b1;
    case (state_q)
      ST_ARB: begin
        if (hs0 && bus.lock0)      state_d = ST_LOCK0;
        else if (hs1 && bus.lock1) state_d = ST_LOCK1;
      end
      ST_LOCK0: if (!bus.lock0) state_d = ST_ARB;
      ST_LOCK1: if (!bus.lock1) state_d = ST_ARB;
      default:  state_d = ST_ARB;
    endcase
  end

  // Address and write data hold between handshakes; web pulses only on a write handshake.
  always_comb begin
    ram_address_d = ram_address_q;
    data_to_ram_d = data_to_ram_q;
    web_d         = 1'b0;
    issue_valid   = 1'b0;
    issue_tag     = 1'b0;
    if (hs0) begin
      ram_address_d = bus.addr0;
      data_to_ram_d = bus.wdata0;
      web_d         = bus.we0;
      issue_valid   = ~bus.we0;
    end else if (hs1) begin
      ram_address_d = bus.addr1;
      data_to_ram_d = bus.wdata1;
      web_d         = bus.we1;
      issue_valid   = ~bus.we1;
      issue_tag     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_ARB;
      last_q        <= 1'b1;
      ram_address_q <= '0;
      data_to_ram_q <= '0;
      web_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      ram_address_q <= ram_address_d;
      data_to_ram_q <= data_to_ram_d;
      web_q         <= web_d;
    end
  end

  arb_return_pipe u_return_pipe (
    .clk         (clk),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_tag   (issue_tag),
    .rvalid0     (ret_valid0),
    .rvalid1     (ret_valid1)
  );

  assign bus.gnt0        = gnt0;
  assign bus.gnt1        = gnt1;
  assign bus.rvalid0     = ret_valid0;
  assign bus.rvalid1     = ret_valid1;
  // Forced to zero outside a return slot, which also clears it while in reset.
  assign bus.rdata       = (ret_valid0 | ret_valid1) ? bus.data_from_ram : '0;
  assign bus.ram_address = ram_address_q;
  assign bus.data_to_ram = data_to_ram_q;
  assign bus.web         = web_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a registered-read RAM model on port B.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(15), .DATA_W(16)) bus ();

  ram_port_arbiter #(.ADDR_W(15), .DATA_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [15:0] mem [0:32767];
  logic        pre_en = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [15:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en)       mem[pre_addr] <= pre_data;
    else if (bus.web) mem[bus.ram_address] <= bus.data_to_ram;
    bus.data_from_ram <= mem[bus.ram_address];
  end

  always @(posedge clk) begin
    if (reset_n && bus.req0 && bus.gnt0)
      $display("txn r0 %s addr=%h wdata=%h", bus.we0 ? "WR" : "RD", bus.addr0, bus.wdata0);
    if (reset_n && bus.req1 && bus.gnt1)
      $display("txn r1 %s addr=%h wdata=%h", bus.we1 ? "WR" : "RD", bus.addr1, bus.wdata1);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.we0 = 0; bus.lock0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.lock1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic preload(input logic [14:0] a, input logic [15:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_en = 1'b0;
  endtask

  initial begin
    idle_inputs();
    preload(15'h0100, 16'hBEEF);
    preload(15'h0001, 16'h1234);
    preload(15'h0002, 16'h5678);

    // Reset state
    bus.req0 = 1'b1;
    #1;
    chk("rst_gnt0", {31'd0, bus.gnt0}, 0);
    chk("rst_web", {31'd0, bus.web}, 0);
    chk("rst_rvalid0", {31'd0, bus.rvalid0}, 0);
    chk("rst_rvalid1", {31'd0, bus.rvalid1}, 0);
    chk("rst_addr", {17'd0, bus.ram_address}, 0);
    chk("rst_wdata", {16'd0, bus.data_to_ram}, 0);
    chk("rst_rdata", {16'd0, bus.rdata}, 0);
    bus.req0 = 1'b0;
    step();
    reset_n = 1'b1;

    // Contest: both requesters read for 4 cycles
    for (int k = 0; k < 6; k++) begin
      chk("cont_web", {31'd0, bus.web}, 0);
      if (k >= 1 && k <= 4) chk("cont_addr", {17'd0, bus.ram_address}, (k % 2 == 1) ? 32'h1 : 32'h2);
      chk("cont_rvalid0", {31'd0, bus.rvalid0}, (k == 2 || k == 4) ? 32'd1 : 32'd0);
      chk("cont_rvalid1", {31'd0, bus.rvalid1}, (k == 3 || k == 5) ? 32'd1 : 32'd0);
      chk("cont_rdata", {16'd0, bus.rdata},
          (k == 2 || k == 4) ? 32'h1234 : (k == 3 || k == 5) ? 32'h5678 : 32'h0);
      if (k < 4) begin
        bus.req0 = 1; bus.addr0 = 15'h0001;
        bus.req1 = 1; bus.addr1 = 15'h0002;
        #1;
        chk("cont_gnt0", {31'd0, bus.gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
        chk("cont_gnt1", {31'd0, bus.gnt1}, (k % 2 == 1) ? 32'd1 : 32'd0);
      end else begin
        idle_inputs();
      end
      step();
    end

    // Single read
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 15'h0100;
    #1;
    chk("sr_gnt0", {31'd0, bus.gnt0}, 1);
    chk("sr_gnt1", {31'd0, bus.gnt1}, 0);
    step();
    idle_inputs();
    chk("sr_addr", {17'd0, bus.ram_address}, 32'h0100);
    chk("sr_web", {31'd0, bus.web}, 0);
    chk("sr_rvalid0_early", {31'd0, bus.rvalid0}, 0);
    step();
    chk("sr_rvalid0", {31'd0, bus.rvalid0}, 1);
    chk("sr_rdata", {16'd0, bus.rdata}, 32'hBEEF);
    chk("sr_rvalid1", {31'd0, bus.rvalid1}, 0);
    step();
    chk("sr_rvalid0_late", {31'd0, bus.rvalid0}, 0);
    chk("sr_addr_hold", {17'd0, bus.ram_address}, 32'h0100);

    // Lock: requester 1 writes three words while requester 0 waits
    for (int l = 0; l < 5; l++) begin
      chk("lk_web", {31'd0, bus.web}, (l >= 1 && l <= 3) ? 32'd1 : 32'd0);
      if (l >= 1 && l <= 3) begin
        chk("lk_addr", {17'd0, bus.ram_address}, 32'h7FFC + 32'(l));
        chk("lk_wdata", {16'd0, bus.data_to_ram}, 32'h1111 * 32'(l));
      end
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 15'h7FFE;
      if (l < 3) begin
        bus.req1 = 1; bus.lock1 = 1; bus.we1 = 1;
        bus.addr1 = 15'(15'h7FFD + l);
        bus.wdata1 = 16'(16'h1111 * (l + 1));
      end else begin
        bus.req1 = 0; bus.lock1 = 0; bus.we1 = 0;
      end
      #1;
      chk("lk_gnt0", {31'd0, bus.gnt0}, (l == 4) ? 32'd1 : 32'd0);
      if (l < 3) chk("lk_gnt1", {31'd0, bus.gnt1}, 1);
      step();
    end
    idle_inputs();
    chk("lk_rd_addr", {17'd0, bus.ram_address}, 32'h7FFE);
    chk("lk_rd_web", {31'd0, bus.web}, 0);
    step();
    chk("lk_rvalid0", {31'd0, bus.rvalid0}, 1);
    chk("lk_rdata", {16'd0, bus.rdata}, 32'h2222);
    step();

    // Write via requester 0, then read back via requester 1
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 15'h0042; bus.wdata0 = 16'hA5A5;
    #1;
    chk("wr_gnt0", {31'd0, bus.gnt0}, 1);
    step();
    chk("wr_web", {31'd0, bus.web}, 1);
    chk("wr_addr", {17'd0, bus.ram_address}, 32'h0042);
    chk("wr_wdata", {16'd0, bus.data_to_ram}, 32'hA5A5);
    idle_inputs();
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 15'h0042;
    #1;
    chk("rd_gnt1", {31'd0, bus.gnt1}, 1);
    chk("rd_gnt0", {31'd0, bus.gnt0}, 0);
    step();
    idle_inputs();
    chk("rd_web", {31'd0, bus.web}, 0);
    chk("rd_addr", {17'd0, bus.ram_address}, 32'h0042);
    step();
    chk("rd_rvalid1", {31'd0, bus.rvalid1}, 1);
    chk("rd_rdata", {16'd0, bus.rdata}, 32'hA5A5);
    chk("rd_rvalid0", {31'd0, bus.rvalid0}, 0);
    step();

    // Reset pulsed while a locked read is in flight
    bus.req1 = 1; bus.lock1 = 1; bus.we1 = 0; bus.addr1 = 15'h0100;
    #1;
    chk("mf_gnt1", {31'd0, bus.gnt1}, 1);
    step();
    chk("mf_addr", {17'd0, bus.ram_address}, 32'h0100);
    bus.req1 = 0;
    bus.req0 = 1;
    reset_n = 1'b0;
    #1;
    chk("mf_gnt0", {31'd0, bus.gnt0}, 0);
    chk("mf_gnt1_rst", {31'd0, bus.gnt1}, 0);
    chk("mf_web", {31'd0, bus.web}, 0);
    chk("mf_ram_addr", {17'd0, bus.ram_address}, 0);
    chk("mf_wdata", {16'd0, bus.data_to_ram}, 0);
    chk("mf_rdata", {16'd0, bus.rdata}, 0);
    step();
    chk("mf_rvalid0", {31'd0, bus.rvalid0}, 0);
    chk("mf_rvalid1", {31'd0, bus.rvalid1}, 0);
    chk("mf_rdata2", {16'd0, bus.rdata}, 0);
    reset_n = 1'b1;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 15'h0002;
    #1;
    chk("mf_post_gnt0", {31'd0, bus.gnt0}, 1);
    step();
    idle_inputs();
    chk("mf_post_addr", {17'd0, bus.ram_address}, 32'h0002);
    step();
    chk("mf_post_rvalid0", {31'd0, bus.rvalid0}, 1);
    chk("mf_post_rdata", {16'd0, bus.rdata}, 32'h5678);
    step();

    // Idle: nothing moves for 10 cycles
    for (int i = 0; i < 10; i++) begin
      chk("idle_web", {31'd0, bus.web}, 0);
      chk("idle_gnt", {30'd0, bus.gnt1, bus.gnt0}, 0);
      chk("idle_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 0);
      chk("idle_addr", {17'd0, bus.ram_address}, 32'h0002);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
